// File: rtl/fpsu_ret_collect.sv
// fpsu_ret_collect: in-order retire FIFO for FP lanes u1/u3/u5 with dual-pop drain, flag accumulation and issue stall.
module fpsu_ret_collect #(
  parameter int DEPTH     = 16,
  parameter int STALL_THR = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] u1_ret,
  input  logic [13:0] u3_ret,
  input  logic [13:0] u5_ret,
  input  logic        u1_ret_en,
  input  logic        u3_ret_en,
  input  logic        u5_ret_en,
  input  logic [8:0]  u1_rob_id,
  input  logic [8:0]  u3_rob_id,
  input  logic [8:0]  u5_rob_id,
  input  logic        flush,
  input  logic        flags_clr,
  input  logic        out_ready,
  output logic        out0_en,
  output logic        out1_en,
  output logic [24:0] out0_data,
  output logic [24:0] out1_data,
  output logic        stall,
  output logic [4:0]  fpflags_acc,
  output logic        ovf_err
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;
  logic [24:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  cnt_t          r_cnt;
  logic          r_stall, r_ovf;
  logic [4:0]    r_flags;
  logic [24:0]   w_ent [3];
  logic [AW-1:0] w_slot [3];
  logic [2:0]    w_req, w_acc;
  logic [1:0]    w_n, w_pops;
  cnt_t          w_room, w_cnt_nxt;
  logic [AW-1:0] w_rd1;
  logic [4:0]    w_pflags;
  assign w_rd1       = r_rd + AW'(1);
  assign out0_en     = r_cnt != '0;
  assign out1_en     = r_cnt > cnt_t'(1);
  assign out0_data   = r_mem[r_rd];
  assign out1_data   = r_mem[w_rd1];
  assign w_pops      = out_ready ? {1'b0, out0_en} + {1'b0, out1_en} : 2'd0;
  assign w_pflags    = out_ready ? ((out0_en ? out0_data[4:0] : 5'd0) | (out1_en ? out1_data[4:0] : 5'd0)) : 5'd0;
  // pops free space before pushes are checked, so a full FIFO can still accept while draining
  assign w_room      = cnt_t'(DEPTH) - r_cnt + cnt_t'(w_pops);
  assign w_cnt_nxt   = r_cnt + cnt_t'(w_n) - cnt_t'(w_pops);
  assign stall       = r_stall;
  assign fpflags_acc = r_flags;
  assign ovf_err     = r_ovf;
  always_comb begin
    w_ent[0] = {2'd0, u1_rob_id, u1_ret};
    w_ent[1] = {2'd1, u3_rob_id, u3_ret};
    w_ent[2] = {2'd2, u5_rob_id, u5_ret};
    w_req    = {u5_ret_en, u3_ret_en, u1_ret_en};
    w_acc    = '0;
    w_n      = '0;
    for (int i = 0; i < 3; i++) begin
      w_slot[i] = r_wr + AW'(w_n);
      w_acc[i]  = w_req[i] && (cnt_t'(w_n) < w_room);
      w_n       = w_n + 2'(w_acc[i]);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (w_acc[i]) r_mem[w_slot[i]] <= w_ent[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_stall <= 1'b0;
      r_flags <= '0;
      r_ovf   <= 1'b0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_stall <= 1'b0;
      r_flags <= flags_clr ? 5'd0 : r_flags;
    end else begin
      r_rd    <= r_rd + AW'(w_pops);
      r_wr    <= r_wr + AW'(w_n);
      r_cnt   <= w_cnt_nxt;
      r_stall <= (cnt_t'(DEPTH) - w_cnt_nxt) < cnt_t'(STALL_THR);
      r_flags <= (flags_clr ? 5'd0 : r_flags) | w_pflags;
      r_ovf   <= r_ovf | (|(w_req & ~w_acc));
    end
  end
endmodule

// File: tb/tb_fpsu_ret_collect.sv
// tb_fpsu_ret_collect: vector table with hand-derived occupancy/flags plus a data scoreboard queue.
module tb_fpsu_ret_collect;
  localparam int DEPTH = 16;
  localparam int THR   = 6;
  logic        clk = 0, rst = 1, flush = 0, flags_clr = 0, out_ready = 0;
  logic [13:0] u1_ret = 0, u3_ret = 0, u5_ret = 0;
  logic        u1_ret_en = 0, u3_ret_en = 0, u5_ret_en = 0;
  logic [8:0]  u1_rob_id = 0, u3_rob_id = 0, u5_rob_id = 0;
  logic        out0_en, out1_en, stall, ovf_err;
  logic [24:0] out0_data, out1_data;
  logic [4:0]  fpflags_acc;
  fpsu_ret_collect #(.DEPTH(DEPTH), .STALL_THR(THR)) dut (
    .clk(clk), .rst(rst),
    .u1_ret(u1_ret), .u3_ret(u3_ret), .u5_ret(u5_ret),
    .u1_ret_en(u1_ret_en), .u3_ret_en(u3_ret_en), .u5_ret_en(u5_ret_en),
    .u1_rob_id(u1_rob_id), .u3_rob_id(u3_rob_id), .u5_rob_id(u5_rob_id),
    .flush(flush), .flags_clr(flags_clr), .out_ready(out_ready),
    .out0_en(out0_en), .out1_en(out1_en), .out0_data(out0_data), .out1_data(out1_data),
    .stall(stall), .fpflags_acc(fpflags_acc), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rst, flush, clr, rdy;
    logic [2:0]  en;
    logic [8:0]  rob;
    logic [13:0] ret;
    int          cnt;
    logic [4:0]  fl;
    logic        ovf;
  } vec_t;
  vec_t        tbl[$];
  logic [24:0] sb[$];
  int          tests = 0, fails = 0;
  function automatic vec_t mk(logic rs, logic fs, logic cl, logic rd, logic [2:0] en, logic [8:0] rob,
                              logic [13:0] ret, int cnt, logic [4:0] fl, logic ovf);
    vec_t v;
    v.rst = rs; v.flush = fs; v.clr = cl; v.rdy = rd; v.en = en; v.rob = rob;
    v.ret = ret; v.cnt = cnt; v.fl = fl; v.ovf = ovf;
    return v;
  endfunction
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL v%0d %s: got %0h, expected %0h", idx, name, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input int idx);
    logic [13:0] r[3];
    logic [8:0]  id[3];
    int          pops, room, k;
    for (int i = 0; i < 3; i++) begin
      id[i] = v.rob + 9'(i);
      r[i]  = v.ret ^ 14'(i << 10);
    end
    rst = v.rst; flush = v.flush; flags_clr = v.clr; out_ready = v.rdy;
    u1_ret_en = v.en[0]; u3_ret_en = v.en[1]; u5_ret_en = v.en[2];
    u1_ret = r[0]; u3_ret = r[1]; u5_ret = r[2];
    u1_rob_id = id[0]; u3_rob_id = id[1]; u5_rob_id = id[2];
    if (sb.size() >= 1) chk("out0_data", idx, 32'(out0_data), 32'(sb[0]));
    if (sb.size() >= 2) chk("out1_data", idx, 32'(out1_data), 32'(sb[1]));
    if (v.rst || v.flush) sb.delete();
    else begin
      pops = v.rdy ? (sb.size() < 2 ? sb.size() : 2) : 0;
      repeat (pops) void'(sb.pop_front());
      room = DEPTH - sb.size();
      k = 0;
      for (int i = 0; i < 3; i++)
        if (v.en[i]) begin
          if (k < room) sb.push_back({2'(i), id[i], r[i]});
          k++;
        end
    end
    @(posedge clk);
    #1;
    chk("out0_en", idx, 32'(out0_en), 32'(v.cnt >= 1));
    chk("out1_en", idx, 32'(out1_en), 32'(v.cnt >= 2));
    chk("stall", idx, 32'(stall), 32'((DEPTH - v.cnt) < THR));
    chk("fpflags_acc", idx, 32'(fpflags_acc), 32'(v.fl));
    chk("ovf_err", idx, 32'(ovf_err), 32'(v.ovf));
  endtask
  initial begin
    //              rst flush clr rdy en      rob     ret      cnt fl     ovf
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 9'h000, 14'h0000, 0, 5'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'b010, 9'h005, 14'h0011, 1, 5'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'b000, 9'h000, 14'h0000, 0, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b111, 9'd10,  14'h0000, 3, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'b000, 9'h000, 14'h0000, 1, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'b000, 9'h000, 14'h0000, 0, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b111, 9'h020, 14'h1A04, 3, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b111, 9'h030, 14'h0120, 6, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b111, 9'h040, 14'h0240, 9, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b111, 9'h050, 14'h0360, 12, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b011, 9'h060, 14'h0480, 14, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b011, 9'h070, 14'h05A0, 16, 5'h11, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'b011, 9'h080, 14'h06C0, 16, 5'h15, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'b000, 9'h000, 14'h0000, 14, 5'h15, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b001, 9'h090, 14'h07E0, 15, 5'h15, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b111, 9'h0A0, 14'h0800, 16, 5'h15, 1));
    for (int c = 14; c >= 0; c -= 2)
      tbl.push_back(mk(0, 0, 0, 1, 3'b000, 9'h000, 14'h0000, c, 5'h15, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'b111, 9'h0B0, 14'h0008, 3, 5'h15, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'b111, 9'h0C0, 14'h0000, 6, 5'h15, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'b001, 9'h0D0, 14'h0000, 7, 5'h15, 1));
    tbl.push_back(mk(0, 1, 0, 1, 3'b111, 9'h0E0, 14'h0010, 0, 5'h15, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'b001, 9'h0F0, 14'h0002, 1, 5'h15, 1));
    tbl.push_back(mk(0, 0, 1, 1, 3'b000, 9'h000, 14'h0000, 0, 5'h02, 1));
    tbl.push_back(mk(0, 0, 1, 0, 3'b000, 9'h000, 14'h0000, 0, 5'h00, 1));
    foreach (tbl[i]) step(tbl[i], i);
    // reset while draining: everything discarded, refill lands in slot 0
    step(mk(0, 0, 0, 0, 3'b111, 9'h100, 14'h001F, 3, 5'h00, 1), 100);
    step(mk(0, 0, 0, 0, 3'b011, 9'h110, 14'h0000, 5, 5'h00, 1), 101);
    step(mk(1, 0, 0, 1, 3'b000, 9'h000, 14'h0000, 0, 5'h00, 0), 102);
    step(mk(0, 0, 0, 0, 3'b100, 9'h120, 14'h2A03, 1, 5'h00, 0), 103);
    step(mk(0, 0, 0, 1, 3'b000, 9'h000, 14'h0000, 0, 5'h03, 0), 104);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
